// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default counter width, default channel count
// and the triangle phase-to-level mapping used by the fade engine.
package pwm_pkg;

    localparam int CTR_LEN_DEF  = 8;
    localparam int CHANNELS_DEF = 8;

    // Folds a phase of width w+1 into a w-bit level.
    // The lower half of the cycle ramps up, and the upper half ramps down.
    function automatic logic [31:0] tri_level(
        input logic [31:0] p,
        input int unsigned w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return p[w] ? (~p & mask) : (p & mask);
    endfunction

endpackage

// File: rtl/pwm_fade_engine_fade_channel.sv
// fade_channel: per-channel level from the shared phase plus a fixed offset.
// Ports: phase (CTR_LEN+1) in, level (CTR_LEN) out. Gamma: PWM_FADE_GAMMA_EN.
module fade_channel
    import pwm_pkg::*;
#(
    parameter int CTR_LEN = CTR_LEN_DEF,
    parameter int OFFSET  = 0
) (
    input  logic [CTR_LEN:0]   phase,
    output logic [CTR_LEN-1:0] level
);

    localparam logic [CTR_LEN:0] OFF = OFFSET[CTR_LEN:0];

    logic [CTR_LEN:0]   p;
    logic [CTR_LEN-1:0] lin;

    assign p   = phase + OFF;
    assign lin = CTR_LEN'(tri_level(32'(p), CTR_LEN));

`ifdef PWM_FADE_GAMMA_EN
    logic [2*CTR_LEN-1:0] sq;

    assign sq    = lin * lin;
    assign level = CTR_LEN'(sq >> CTR_LEN);
`else
    assign level = lin;
`endif

endmodule

// File: rtl/pwm_fade_engine.sv
// pwm_fade_engine: triangle "breathing" duty values, reloaded once per PWM period.
// Ports: clk, rst (sync, active-high), en, ctr_value in; duty, frame_tick out.
// Optional gamma curve: define PWM_FADE_GAMMA_EN.
module pwm_fade_engine
    import pwm_pkg::*;
#(
    parameter int CHANNELS     = CHANNELS_DEF,
    parameter int CTR_LEN      = CTR_LEN_DEF,
    parameter int STEP_PERIODS = 4,
    parameter int PHASE_STEP   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [CTR_LEN-1:0]          ctr_value,
    output logic [CHANNELS*CTR_LEN-1:0] duty,
    output logic                        frame_tick
);

    localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(STEP_PERIODS - 1);
    localparam int PH_MOD = 1 << (CTR_LEN + 1);

    logic                        period_end;
    logic [PW-1:0]               pcnt_q, pcnt_d;
    logic [CTR_LEN:0]            phase_q, phase_d;
    logic [CHANNELS*CTR_LEN-1:0] duty_q, duty_d;
    logic                        frame_tick_q, frame_tick_d;
    logic [CHANNELS*CTR_LEN-1:0] level;

    assign period_end = &ctr_value;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        fade_channel #(
            .CTR_LEN (CTR_LEN),
            .OFFSET  ((i * PHASE_STEP) % PH_MOD)
        ) u_ch (
            .phase (phase_q),
            .level (level[i*CTR_LEN +: CTR_LEN])
        );
    end

    // Duty always reloads from the pre-edge phase, so a phase step
    // shows up on duty one period later.
    always_comb begin
        pcnt_d       = pcnt_q;
        phase_d      = phase_q;
        duty_d       = duty_q;
        frame_tick_d = 1'b0;
        if (period_end) begin
            frame_tick_d = 1'b1;
            duty_d       = level;
            if (en) begin
                if (pcnt_q == PCNT_LAST) begin
                    pcnt_d  = '0;
                    phase_d = phase_q + 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            phase_q      <= '0;
            duty_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign duty       = duty_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pwm_fade_engine.sv
// Directed bench for pwm_fade_engine: STEP_PERIODS=1 and STEP_PERIODS=3
// instances share the counter and enable inputs.
module tb_pwm_fade_engine;
    import pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  ctr;
    logic [63:0] duty1, duty3;
    logic        ft1, ft3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_fade_engine #(
        .CHANNELS(8), .CTR_LEN(8), .STEP_PERIODS(1), .PHASE_STEP(32)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .ctr_value(ctr),
        .duty(duty1), .frame_tick(ft1)
    );

    pwm_fade_engine #(
        .CHANNELS(8), .CTR_LEN(8), .STEP_PERIODS(3), .PHASE_STEP(32)
    ) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .ctr_value(ctr),
        .duty(duty3), .frame_tick(ft3)
    );

    typedef struct {
        logic en;
        int   n;
        int   len;
        int   ticks;
        int   d0;
        int   d1;
        int   d7;
        int   d30;
    } vec_t;

    vec_t vt[8];

    function automatic int fx(input int x);
`ifdef PWM_FADE_GAMMA_EN
        return (x * x) >> 8;
`else
        return x;
`endif
    endfunction

    function automatic int ch(input logic [63:0] d, input int i);
        return int'(d[i*8 +: 8]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Runs n periods of len cycles (last count is all-ones), then stops
    // 1 time unit after the final reload edge.
    task automatic run_periods(input int n, input int len, output int ticks);
        ticks = 0;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                ticks += int'(ft1);
                ctr = (c == len - 1) ? 8'hff : 8'(c);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tk;

        vt[0] = '{1'b1,   1, 256,   0,   0,  32, 224,   0};
        vt[1] = '{1'b1,  40,   4,  40,  40,  72, 247,  13};
        vt[2] = '{1'b0,  10,   4,  10,  41,  73, 246,  13};
        vt[3] = '{1'b1,   1,   4,   1,  41,  73, 246,  13};
        vt[4] = '{1'b1, 214,   4, 214, 255, 224,  32,  85};
        vt[5] = '{1'b1,   1,   4,   1, 255, 223,  31,  85};
        vt[6] = '{1'b1, 255,   4, 255,   0,  31, 223, 170};
        vt[7] = '{1'b1,   1,   4,   1,   0,  32, 224, 170};

        chk("tri_level_down", int'(tri_level(32'd300, 8)), 211);
        chk("tri_level_up", int'(tri_level(32'd77, 8)), 77);

        rst = 1'b1;
        en  = 1'b0;
        ctr = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_duty_nonzero", int'(duty1 != 64'd0), 0);
        chk("reset_duty3_nonzero", int'(duty3 != 64'd0), 0);
        chk("reset_frame_tick", int'(ft1), 0);
        rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            en = vt[r].en;
            run_periods(vt[r].n, vt[r].len, tk);
            chk($sformatf("row%0d_d0", r), ch(duty1, 0), fx(vt[r].d0));
            chk($sformatf("row%0d_d1", r), ch(duty1, 1), fx(vt[r].d1));
            chk($sformatf("row%0d_d7", r), ch(duty1, 7), fx(vt[r].d7));
            chk($sformatf("row%0d_step3_d0", r), ch(duty3, 0),
                fx(vt[r].d30));
            chk($sformatf("row%0d_tick", r), int'(ft1), 1);
            chk($sformatf("row%0d_tick3", r), int'(ft3), 1);
            chk($sformatf("row%0d_tick_count", r), tk, vt[r].ticks);
        end

        // Reset in the middle of a period with nonzero duties.
        @(negedge clk);
        ctr = 8'd5;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_duty_nonzero", int'(duty1 != 64'd0), 0);
        chk("midrst_duty3_nonzero", int'(duty3 != 64'd0), 0);
        chk("midrst_tick", int'(ft1), 0);
        rst = 1'b0;
        ctr = 8'd7;
        repeat (20) @(negedge clk);
        chk("midrst_hold_nonzero", int'(duty1 != 64'd0), 0);
        chk("midrst_hold_tick", int'(ft1), 0);
        en = 1'b1;
        run_periods(1, 4, tk);
        chk("postrst_d0", ch(duty1, 0), fx(0));
        chk("postrst_d1", ch(duty1, 1), fx(32));
        chk("postrst_d7", ch(duty1, 7), fx(224));
        chk("postrst_step3_d1", ch(duty3, 1), fx(32));
        chk("postrst_tick", int'(ft1), 1);
        chk("postrst_tick_count", tk, 0);

        // Reset coinciding with a period end.
        @(negedge clk);
        ctr = 8'hff;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wins_duty_nonzero", int'(duty1 != 64'd0), 0);
        chk("rst_wins_tick", int'(ft1), 0);
        @(negedge clk);
        rst = 1'b0;
        ctr = 8'd0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
